// File: rtl/cache_pkg.sv
// Width-independent helpers shared by the multi-port read-protected cache.
// raddr_i / rdata_o pack port p at [p*W +: W], so port 0 sits in the LSBs.
package cache_pkg;

   function automatic int tag_width(input int addr_w, input int idx_w);
      return addr_w - idx_w;
   endfunction

endpackage

// File: rtl/cache_rd_port.sv
// One read port: tag compare against the selected entry, consume request,
// and the one-cycle response registers.
module cache_rd_port #(
   parameter int TAG_W           = 6,
   parameter int DATA_WIDTH      = 16,
   parameter int CONSUME_ON_READ = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rreq,
   input  logic [TAG_W-1:0]      rtag,
   input  logic                  e_valid,
   input  logic [TAG_W-1:0]      e_tag,
   input  logic [DATA_WIDTH-1:0] e_data,
   output logic                  consume,
   output logic                  rvalid,
   output logic                  rhit,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic                  hit;
   logic                  rvalid_q, rhit_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   assign hit     = rreq & e_valid & (e_tag == rtag);
   assign consume = hit & (CONSUME_ON_READ != 0);

   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         rhit_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rreq;
         rhit_q   <= hit;
         rdata_q  <= hit ? e_data : '0;
      end
   end

   // A response still in flight when reset rises is dropped, not shown.
   assign rvalid = rvalid_q & ~reset;
   assign rhit   = rhit_q & ~reset;
   assign rdata  = reset ? '0 : rdata_q;

endmodule

// File: rtl/cache_mp_rp.sv
// Direct-mapped tagged result store: one write port, NUM_RD_PORTS read ports,
// pending entries are write-protected until a read port consumes them.
module cache_mp_rp
   import cache_pkg::*;
#(
   parameter int IDX_BITS        = 2,
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 8,
   parameter int NUM_RD_PORTS    = 2,
   parameter int CONSUME_ON_READ = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush_i,
   input  logic                               wvalid_i,
   input  logic [ADDR_WIDTH-1:0]              waddr_i,
   input  logic [DATA_WIDTH-1:0]              wdata_i,
   output logic                               wready_o,
   input  logic [NUM_RD_PORTS-1:0]            rreq_i,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_RD_PORTS-1:0]            rvalid_o,
   output logic [NUM_RD_PORTS-1:0]            rhit_o,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rdata_o,
   output logic [IDX_BITS:0]                  occupancy_o
);

   localparam int NUM_ENTRIES = 2**IDX_BITS;
   localparam int TAG_W       = tag_width(ADDR_WIDTH, IDX_BITS);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_W-1:0]      stored_tag;
   } entry_t;

   entry_t                                     mem [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]                     valid, pending, pending_nxt, consume_vec;
   logic [NUM_RD_PORTS-1:0]                    consume;
   logic [NUM_RD_PORTS-1:0][IDX_BITS-1:0]      ridx;
   logic [IDX_BITS:0]                          occ_nxt;
   logic [IDX_BITS-1:0]                        widx;
   logic [TAG_W-1:0]                           wtag;
   logic                                       wr_fire;

   assign widx     = waddr_i[IDX_BITS-1:0];
   assign wtag     = waddr_i[ADDR_WIDTH-1:IDX_BITS];
   // Deliberately no path from rreq_i: a same-cycle consume cannot unblock.
   assign wready_o = ~reset & ~flush_i & ~(valid[widx] & pending[widx]);
   assign wr_fire  = wvalid_i & wready_o;

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      assign ra      = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign ridx[p] = ra[IDX_BITS-1:0];

      cache_rd_port #(
         .TAG_W          (TAG_W),
         .DATA_WIDTH     (DATA_WIDTH),
         .CONSUME_ON_READ(CONSUME_ON_READ)
      ) u_rd (
         .clk    (clk),
         .reset  (reset),
         .rreq   (rreq_i[p]),
         .rtag   (ra[ADDR_WIDTH-1:IDX_BITS]),
         .e_valid(valid[ridx[p]]),
         .e_tag  (mem[ridx[p]].stored_tag),
         .e_data (mem[ridx[p]].data),
         .consume(consume[p]),
         .rvalid (rvalid_o[p]),
         .rhit   (rhit_o[p]),
         .rdata  (rdata_o[p*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Several ports hitting one entry collapse into a single clear; a write
   // to the same index is applied afterwards so its pending bit wins.
   always_comb begin
      consume_vec = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++)
         if (consume[p]) consume_vec[ridx[p]] = 1'b1;
      pending_nxt = pending & ~consume_vec;
      if (wr_fire) pending_nxt[widx] = (CONSUME_ON_READ != 0);
      if (flush_i) pending_nxt = '0;
      occ_nxt = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         occ_nxt = occ_nxt + {{IDX_BITS{1'b0}}, pending_nxt[i]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid       <= '0;
         pending     <= '0;
         occupancy_o <= '0;
      end else begin
         if (flush_i)      valid       <= '0;
         else if (wr_fire) valid[widx] <= 1'b1;
         pending     <= pending_nxt;
         occupancy_o <= occ_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[widx] <= '{data: wdata_i, stored_tag: wtag};
   end

endmodule

// File: tb/tb_cache_mp_rp.sv
// Directed bench: read expectations go through a scoreboard queue and are
// popped by a monitor when responses appear; state checks are inline.
module tb_cache_mp_rp;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NP = 2;
   localparam int IB = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush_i = 1'b0;
   logic             wvalid_i = 1'b0;
   logic [AW-1:0]    waddr_i = '0;
   logic [DW-1:0]    wdata_i = '0;
   logic [NP-1:0]    rreq_i = '0;
   logic [NP*AW-1:0] raddr_i = '0;

   logic             wready_o, wready_n;
   logic [NP-1:0]    rvalid_o, rhit_o, rvalid_n, rhit_n;
   logic [NP*DW-1:0] rdata_o, rdata_n;
   logic [IB:0]      occupancy_o, occupancy_n;

   typedef struct {
      int            port;
      logic          hit;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   cache_mp_rp #(.IDX_BITS(IB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                 .NUM_RD_PORTS(NP), .CONSUME_ON_READ(1)) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i), .wvalid_i(wvalid_i),
      .waddr_i(waddr_i), .wdata_i(wdata_i), .wready_o(wready_o),
      .rreq_i(rreq_i), .raddr_i(raddr_i), .rvalid_o(rvalid_o),
      .rhit_o(rhit_o), .rdata_o(rdata_o), .occupancy_o(occupancy_o));

   cache_mp_rp #(.IDX_BITS(IB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                 .NUM_RD_PORTS(NP), .CONSUME_ON_READ(0)) dut_nc (
      .clk(clk), .reset(reset), .flush_i(flush_i), .wvalid_i(wvalid_i),
      .waddr_i(waddr_i), .wdata_i(wdata_i), .wready_o(wready_n),
      .rreq_i(rreq_i), .raddr_i(raddr_i), .rvalid_o(rvalid_n),
      .rhit_o(rhit_n), .rdata_o(rdata_n), .occupancy_o(occupancy_n));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic idle();
      wvalid_i = 1'b0;
      rreq_i   = '0;
      flush_i  = 1'b0;
   endtask

   task automatic next();
      @(negedge clk);
      idle();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wvalid_i = 1'b1;
      waddr_i  = a;
      wdata_i  = d;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a, input logic h, input logic [DW-1:0] d);
      rreq_i[p]             = 1'b1;
      raddr_i[p*AW +: AW]   = a;
      sb.push_back('{p, h, d});
   endtask

   // Responses to reads sampled at this edge are visible 2 time units later.
   always @(posedge clk) begin
      exp_t e;
      #2;
      for (int p = 0; p < NP; p++) begin
         if (sb.size() > 0 && sb[0].port == p) begin
            e = sb.pop_front();
            chk($sformatf("rvalid%0d", p), 32'(rvalid_o[p]), 32'd1);
            chk($sformatf("rhit%0d", p), 32'(rhit_o[p]), 32'(e.hit));
            chk($sformatf("rdata%0d", p), 32'(rdata_o[p*DW +: DW]), 32'(e.data));
         end else begin
            chk($sformatf("rvalid%0d_idle", p), 32'(rvalid_o[p]), 32'd0);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("occ_reset", 32'(occupancy_o), 0);
      #1 chk("wready_idle", 32'(wready_o), 1);

      // cold reads miss on both ports
      rd(0, 8'h05, 1'b0, '0); rd(1, 8'h05, 1'b0, '0);
      next();
      chk("occ_cold", 32'(occupancy_o), 0);

      // write then consume
      wr(8'h05, 16'hBEEF);
      #1 chk("wready_w05", 32'(wready_o), 1);
      next();
      chk("occ_w05", 32'(occupancy_o), 1);
      rd(0, 8'h05, 1'b1, 16'hBEEF);
      next();
      chk("occ_consumed", 32'(occupancy_o), 0);

      // read protection and hold
      wr(8'h05, 16'h1111);
      #1 chk("wready_w05b", 32'(wready_o), 1);
      next();
      wr(8'h09, 16'h2222);
      #1 chk("wready_blocked", 32'(wready_o), 0);
      next();
      wr(8'h09, 16'h2222);
      rd(1, 8'h05, 1'b1, 16'h1111);
      #1 chk("wready_consume_same_cycle", 32'(wready_o), 0);
      next();
      wr(8'h09, 16'h2222);
      #1 chk("wready_after_consume", 32'(wready_o), 1);
      next();
      rd(0, 8'h05, 1'b0, '0); rd(1, 8'h09, 1'b1, 16'h2222);
      next();
      chk("occ_evict", 32'(occupancy_o), 0);

      // dual-port hit consumes once
      wr(8'h0A, 16'hAAAA);
      next();
      wr(8'h05, 16'hBEEF);
      #1 chk("wready_w05c", 32'(wready_o), 1);
      next();
      chk("occ_two", 32'(occupancy_o), 2);
      rd(0, 8'h05, 1'b1, 16'hBEEF); rd(1, 8'h05, 1'b1, 16'hBEEF);
      next();
      chk("occ_dual_hit", 32'(occupancy_o), 1);
      rd(0, 8'h0A, 1'b1, 16'hAAAA);
      next();
      chk("occ_after_0A", 32'(occupancy_o), 0);

      // fill, then flush alongside a write and a read
      for (int i = 0; i < 4; i++) begin
         wr(8'(8'h10 + i), 16'(16'h1000 + i));
         next();
      end
      chk("occ_full", 32'(occupancy_o), 4);
      waddr_i = 8'h14;
      #1 chk("wready_full", 32'(wready_o), 0);
      flush_i = 1'b1;
      wr(8'h21, 16'h5555);
      rd(0, 8'h12, 1'b1, 16'h1002);
      #1 chk("wready_flush", 32'(wready_o), 0);
      next();
      chk("occ_flush", 32'(occupancy_o), 0);
      rd(0, 8'h10, 1'b0, '0); rd(1, 8'h13, 1'b0, '0);
      next();
      rd(0, 8'h21, 1'b0, '0);
      next();

      // reset while a response is in flight: no pulse, nothing queued
      rreq_i[0]     = 1'b1;
      raddr_i[7:0]  = 8'h11;
      @(posedge clk);
      #1;
      reset  = 1'b1;
      rreq_i = '0;
      @(negedge clk);
      chk("rvalid_in_reset", 32'(rvalid_o), 0);
      @(negedge clk);
      reset = 1'b0;
      chk("occ_after_reset", 32'(occupancy_o), 0);

      // no write protection when reads do not consume
      wr(8'h05, 16'h1234);
      #1 chk("wready_nc_1", 32'(wready_n), 1);
      next();
      chk("occ_nc_1", 32'(occupancy_n), 0);
      wr(8'h09, 16'h5678);
      #1 chk("wready_nc_2", 32'(wready_n), 1);
      chk("wready_c_blocks", 32'(wready_o), 0);
      next();
      chk("occ_nc_2", 32'(occupancy_n), 0);
      rd(0, 8'h09, 1'b0, '0);
      next();
      chk("nc_rhit", 32'(rhit_n[0]), 1);
      chk("nc_rdata", 32'(rdata_n[DW-1:0]), 32'h5678);
      chk("occ_nc_3", 32'(occupancy_n), 0);

      next();
      next();
      chk("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
